// File: rtl/nios2_ls_sysid_pkg.sv
// rtl/nios2_ls_sysid_pkg.sv - shared types and constants for the sysid checker
package nios2_ls_sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ID,
        ST_RD_TS,
        ST_CHECK,
        ST_FIN
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam int WAIT_W  = 16;
    localparam int RETRY_W = 4;

endpackage

// File: rtl/nios2_ls_avm_read_timeout.sv
// rtl/nios2_ls_avm_read_timeout.sv - single Avalon-MM read with stall timeout and retry
module nios2_ls_avm_read_timeout
    import nios2_ls_sysid_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRIES    = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic i_issue,
    input  logic i_addr,
    input  logic i_waitrequest,
    output logic o_read,
    output logic o_address,
    output logic o_ack,
    output logic o_timeout
);

    logic               r_read;
    logic               r_address;
    logic               r_gap;
    logic [WAIT_W-1:0]  r_wait;
    logic [RETRY_W-1:0] r_retry;
    logic               w_expired;

    // Expiry fires on the stalled cycle that brings the count up to TIMEOUT_CYCLES.
    assign w_expired = r_read && i_waitrequest && (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1));

    assign o_read    = r_read;
    assign o_address = r_address;
    assign o_ack     = r_read && !i_waitrequest;
    assign o_timeout = w_expired && (r_retry == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_read    <= 1'b0;
            r_address <= 1'b0;
            r_gap     <= 1'b0;
            r_wait    <= '0;
            r_retry   <= '0;
        end else if (i_issue) begin
            r_read    <= 1'b1;
            r_address <= i_addr;
            r_gap     <= 1'b0;
            r_wait    <= '0;
            r_retry   <= RETRY_W'(MAX_RETRIES);
        end else if (r_read) begin
            if (!i_waitrequest) begin
                r_read <= 1'b0;
                r_wait <= '0;
            end else if (w_expired) begin
                r_read <= 1'b0;
                r_wait <= '0;
                if (r_retry != '0) begin
                    r_gap   <= 1'b1;
                    r_retry <= r_retry - 1'b1;
                end
            end else begin
                r_wait <= r_wait + 1'b1;
            end
        end else if (r_gap) begin
            r_gap  <= 1'b0;
            r_read <= 1'b1;
        end
    end

endmodule

// File: rtl/nios2_ls_sysid_checker.sv
// rtl/nios2_ls_sysid_checker.sv - reads sysid ID/timestamp and compares to build-time values
module nios2_ls_sysid_checker
    import nios2_ls_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'd1537772048,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    state_t      r_state;
    logic        r_busy;
    logic        r_done;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic        r_timeout_err;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;

    logic w_accept;
    logic w_issue;
    logic w_issue_addr;
    logic w_ack;
    logic w_timeout;

    // The next read is launched on the same edge the previous one completes,
    // so the engine's strobe lines up with the FSM state.
    assign w_accept     = start && ((r_state == ST_IDLE) || (r_state == ST_FIN));
    assign w_issue      = w_accept || ((r_state == ST_RD_ID) && w_ack);
    assign w_issue_addr = w_accept ? SYSID_ADDR_ID : SYSID_ADDR_TS;

    nios2_ls_avm_read_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES)
    ) u_rd (
        .clock        (clock),
        .reset        (reset),
        .i_issue      (w_issue),
        .i_addr       (w_issue_addr),
        .i_waitrequest(avm_waitrequest),
        .o_read       (avm_read),
        .o_address    (avm_address),
        .o_ack        (w_ack),
        .o_timeout    (w_timeout)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_id_ok       <= 1'b0;
            r_ts_ok       <= 1'b0;
            r_timeout_err <= 1'b0;
            r_id_value    <= '0;
            r_ts_value    <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    if (start) begin
                        r_state       <= ST_RD_ID;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_id_ok       <= 1'b0;
                        r_ts_ok       <= 1'b0;
                        r_timeout_err <= 1'b0;
                        r_id_value    <= '0;
                        r_ts_value    <= '0;
                    end
                end
                ST_RD_ID: begin
                    if (w_ack) begin
                        r_id_value <= avm_readdata;
                        r_state    <= ST_RD_TS;
                    end else if (w_timeout) begin
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= ST_FIN;
                    end
                end
                ST_RD_TS: begin
                    if (w_ack) begin
                        r_ts_value <= avm_readdata;
                        r_state    <= ST_CHECK;
                    end else if (w_timeout) begin
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= ST_FIN;
                    end
                end
                ST_CHECK: begin
                    r_id_ok <= (r_id_value == EXPECTED_ID);
                    r_ts_ok <= (r_ts_value == EXPECTED_TS);
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_FIN;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign id_ok       = r_id_ok;
    assign ts_ok       = r_ts_ok;
    assign timeout_err = r_timeout_err;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;

endmodule
